bcau_stream: RTL and testbench
==============================

// Module: bcau_stream
// PURPOSE
//  Parametrised streaming brightness-compensation unit for the IRU -> HEU path.
//  - Buffers one frame of DEPTH beats; each beat carries LANES pixels.
//  - Computes each lane's mean and re-emits the frame with every lane re-centred on TARGET.
//  - Replaces the fixed 5x80 whole-array interface with valid/ready streaming.
//  - Adds a runtime bypass mode.
// PARAMETERS
//  LANES   5    pixels per beat (independent lanes, one mean each)
//  DEPTH   80   beats per frame, >=2
//  PIX_W   8    pixel width, bits
//  TARGET  128  re-centring level, must fit in PIX_W
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst        in   1              asynchronous, active-high reset
//  mode       in   1              0=bypass, 1=normalise; sampled on first accepted beat of a frame
//  in_valid   in   1              input beat valid
//  in_ready   out  1              block can accept a beat
//  in_data    in   LANES*PIX_W    lane i at bits [i*PIX_W +: PIX_W]
//  in_last    in   1              producer marks final beat of frame
//  out_valid  out  1              output beat valid
//  out_ready  in   1              consumer accepts the beat
//  out_data   out  LANES*PIX_W    compensated pixels, same lane packing as in_data
//  out_last   out  1              final beat of the output frame
//  frame_err  out  1              sticky: in_last disagreed with beat count; cleared only by rst
// BEHAVIOUR
//  Reset: state=LOAD, counters=0, sums=0, means=0. Outputs: in_ready=1, out_valid=0, out_last=0, frame_err=0, out_data=0.
//  Handshake: a beat transfers when valid&&ready on a rising edge.
//   - Producer holds data stable while valid&&!ready.
//   - out_valid is never dropped before out_ready.
//  FSM:
//   - LOAD: in_ready=1. Each accepted beat is written to buf[wr_cnt]; sum[i]+=pix[i].
//     - Sum width is SUM_W = PIX_W+$clog2(DEPTH).
//     - On the beat with wr_cnt==DEPTH-1 -> DIV. The frame always ends on count; in_last is never used to end it.
//     - frame_err sets if in_last != (wr_cnt==DEPTH-1) on any accepted beat.
//   - DIV: in_ready=0. Per-lane sequential divide mean[i] = floor(sum[i]/DEPTH) takes exactly SUM_W cycles, then -> DRAIN.
//     - mode==0 skips DIV and goes straight LOAD->DRAIN.
//   - DRAIN: in_ready=0, out_valid=1.
//     - out_data lane i = clamp(buf[rd_cnt][i] - mean[i] + TARGET, 0, 2^PIX_W-1).
//     - Arithmetic is signed, PIX_W+2 bits.
//     - In bypass, out_data lane i = buf[rd_cnt][i].
//     - out_last = (rd_cnt==DEPTH-1). An accepted last beat clears sums/counters and goes to LOAD.
//  Latency: last input beat -> first out_valid = SUM_W+1 cycles (normalise) or 1 cycle (bypass).
//  Boundaries:
//   - No overlap: the next frame is not accepted until the DRAIN of the previous frame completes.
//   - Mode changes mid-frame are ignored until the next frame.
//   - Saturation applies at both ends; a flat frame outputs TARGET on every pixel.
//   - rst asserted in any state aborts the frame immediately, with no partial output. Buffer contents are don't-care.
// CONFIGURATION
//  BCAU_STATS_EN defined:
//   - Adds output port stat_mean (LANES*PIX_W).
//   - Adds output port stat_valid (1-cycle pulse on DIV->DRAIN).
//   - stat_mean holds the per-lane means until the next pulse; reset value 0.
//   - stat_valid never pulses in bypass.
//  BCAU_STATS_EN undefined: neither port exists; no extra registers.
// STRUCTURE
//  Package bcau_pkg:
//   - state_t enum {LOAD, DIV, DRAIN}.
//   - Function sat_pix(signed value, width) for the clamp.
//   - Localparam helpers for SUM_W and CNT_W.
//  Sub-module bcau_div_seq:
//   - Restoring divider, one instance per lane in a generate loop.
//   - Parameters: dividend width SUM_W; constant divisor DEPTH.
//   - Ports: start, done, quotient.
//  Frame buffer is a DEPTH x LANES*PIX_W register array inferred in the top module.
// TESTING
//  1 Reset: hold rst 3 cycles mid-LOAD -> in_ready=1, out_valid=0, frame_err=0; the next full frame is processed correctly.
//  2 Flat frame: LANES=5, DEPTH=80, all pixels 40, mode=1 -> 80 out beats, every lane=128, out_last only on beat 79.
//  3 Ramp with saturation: lane0 pixel=beat index*3 (0..237), mean 118 -> out=p+10; beats with p>=246 would clamp, none here.
//     - Lane1: pixel 255 on beat 0, 0 elsewhere -> mean 3. Beat0 -> 255 (clamped from 380); other beats -> 125.
//  4 Bypass: mode=1 on a frame's first beat then mode=0 mid-frame -> that frame normalises.
//     - Next frame starts with mode=0 -> first out_valid 1 cycle after its last beat; output equals input.
//  5 Backpressure: out_ready random 30% -> no beat lost or duplicated; out_data is stable while stalled; in_ready=0 throughout DRAIN.
//  6 Framing error: in_last asserted on beat 50 of 80 -> frame_err sets that cycle and stays 1.
//     - The frame still completes at beat 79 with correct output.

Source files
------------

// File: rtl/bcau_stream_pkg.sv
// Shared types and helpers for the bcau_stream brightness-compensation unit.
// The optional statistics outputs are enabled by the BCAU_STATS_EN macro in bcau_stream.
package bcau_pkg;

   typedef enum logic [1:0] {LOAD, DIV, DRAIN} state_t;

   function automatic int cnt_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int sum_w(input int pixW, input int depth);
      return pixW + $clog2(depth);
   endfunction

   // Clamp a signed intermediate into the unsigned pixel range [0, 2^width-1].
   function automatic logic signed [31:0] sat_pix(input logic signed [31:0] value, input int width);
      logic signed [31:0] maxVal;
      maxVal = (32'sd1 <<< width) - 32'sd1;
      if (value < 0) return '0;
      if (value > maxVal) return maxVal;
      return value;
   endfunction

endpackage

// File: rtl/bcau_stream_if.sv
// Valid/ready stream bundle for bcau_stream: input beats in, compensated beats out.
interface bcau_stream_if #(
   parameter int LANES = 5,
   parameter int PIX_W = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*PIX_W-1:0] in_data;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*PIX_W-1:0] out_data;
   logic                   out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/bcau_stream_div_seq.sv
// Restoring divider by the constant DEPTH; the start cycle already performs the first of SUM_W steps,
// so done is high in the last of SUM_W busy cycles and the quotient then holds until the next start.
module bcau_div_seq
   import bcau_pkg::*;
#(
   parameter int SUM_W = 15,
   parameter int DEPTH = 80,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SUM_W-1:0] dividend,
   output logic             done,
   output logic [OUT_W-1:0] quotient
);
   localparam int REM_W  = cnt_w(DEPTH);
   localparam int STEP_W = $clog2(SUM_W);
   localparam logic [REM_W:0]   DIVISOR    = (REM_W+1)'(DEPTH);
   localparam logic [REM_W-1:0] DIVISOR_LO = REM_W'(DEPTH);

   logic [REM_W-1:0]  r_rem, w_srcRem, w_rem;
   logic [SUM_W-1:0]  r_quo, w_srcQuo;
   logic [REM_W:0]    w_trial;
   logic              w_ge, r_busy;
   logic [STEP_W-1:0] r_steps;

   // The remainder stays below DEPTH, so the subtraction can be done modulo 2^REM_W.
   always_comb begin
      w_srcRem = start ? '0 : r_rem;
      w_srcQuo = start ? dividend : r_quo;
      w_trial  = {w_srcRem, w_srcQuo[SUM_W-1]};
      w_ge     = (w_trial >= DIVISOR);
      w_rem    = w_ge ? (w_trial[REM_W-1:0] - DIVISOR_LO) : w_trial[REM_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem   <= '0;
         r_quo   <= '0;
         r_busy  <= 1'b0;
         r_steps <= '0;
      end else if (start) begin
         r_rem   <= w_rem;
         r_quo   <= {w_srcQuo[SUM_W-2:0], w_ge};
         r_busy  <= 1'b1;
         r_steps <= STEP_W'(SUM_W-1);
      end else if (r_busy) begin
         if (r_steps != '0) begin
            r_rem   <= w_rem;
            r_quo   <= {w_srcQuo[SUM_W-2:0], w_ge};
            r_steps <= r_steps - STEP_W'(1);
         end else begin
            r_busy <= 1'b0;
         end
      end
   end

   assign done     = r_busy && (r_steps == '0);
   assign quotient = r_quo[OUT_W-1:0];
endmodule

// File: rtl/bcau_stream.sv
// Streaming brightness compensation: buffer a frame, divide per-lane sums, re-emit re-centred on TARGET.
// Define BCAU_STATS_EN to add the stat_mean/stat_valid statistics outputs.
module bcau_stream
   import bcau_pkg::*;
#(
   parameter int LANES  = 5,
   parameter int DEPTH  = 80,
   parameter int PIX_W  = 8,
   parameter int TARGET = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   bcau_stream_if.slave       bus,
   output logic               frame_err
`ifdef BCAU_STATS_EN
   ,
   output logic [LANES*PIX_W-1:0] stat_mean,
   output logic               stat_valid
`endif
);
   localparam int SUM_W = sum_w(PIX_W, DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(DEPTH-1);
   localparam logic signed [PIX_W+1:0] TGT       = (PIX_W+2)'(TARGET);

   state_t                 r_state, w_nextState;
   logic [CNT_W-1:0]       r_wrCnt, r_rdCnt;
   logic [SUM_W-1:0]       r_sum [LANES];
   logic [SUM_W-1:0]       w_sumNext [LANES];
   logic [LANES*PIX_W-1:0] r_buf [DEPTH];
   logic [LANES*PIX_W-1:0] w_rdBeat;
   logic [PIX_W-1:0]       w_mean [LANES];
   logic [PIX_W-1:0]       w_outLane [LANES];
   logic [LANES-1:0]       w_divDone;
   logic                   r_mode, r_frameErr;
   logic                   w_inFire, w_outFire, w_inLastBeat, w_outLastBeat, w_divStart, w_divEnd;

   assign w_inFire      = bus.in_valid && bus.in_ready;
   assign w_outFire     = bus.out_valid && bus.out_ready;
   assign w_inLastBeat  = (r_wrCnt == LAST_BEAT);
   assign w_outLastBeat = (r_rdCnt == LAST_BEAT);
   assign w_divStart    = w_inFire && w_inLastBeat && r_mode;
   assign w_divEnd      = (r_state == DIV) && (&w_divDone);
   assign w_rdBeat      = r_buf[r_rdCnt];
   assign frame_err     = r_frameErr;

   // Dividers see the sum including the final beat, so division starts on the same edge that ends LOAD.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [PIX_W+1:0] w_diff;

      assign w_sumNext[i] = r_sum[i] + {{(SUM_W-PIX_W){1'b0}}, bus.in_data[i*PIX_W +: PIX_W]};

      bcau_div_seq #(.SUM_W(SUM_W), .DEPTH(DEPTH), .OUT_W(PIX_W)) u_div (
         .clk      (clk),
         .rst      (rst),
         .start    (w_divStart),
         .dividend (w_sumNext[i]),
         .done     (w_divDone[i]),
         .quotient (w_mean[i])
      );

      assign w_diff = $signed({2'b00, w_rdBeat[i*PIX_W +: PIX_W]}) - $signed({2'b00, w_mean[i]}) + TGT;
      assign w_outLane[i] = (r_state != DRAIN) ? '0 :
                            r_mode ? PIX_W'(sat_pix(32'(w_diff), PIX_W)) : w_rdBeat[i*PIX_W +: PIX_W];
   end

   always_comb begin
      w_nextState   = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = '0;
      for (int i = 0; i < LANES; i++) bus.out_data[i*PIX_W +: PIX_W] = w_outLane[i];
      unique case (r_state)
         LOAD: begin
            bus.in_ready = 1'b1;
            if (w_inFire && w_inLastBeat) w_nextState = r_mode ? DIV : DRAIN;
         end
         DIV: if (&w_divDone) w_nextState = DRAIN;
         DRAIN: begin
            bus.out_valid = 1'b1;
            bus.out_last  = w_outLastBeat;
            if (w_outFire && w_outLastBeat) w_nextState = LOAD;
         end
         default: w_nextState = LOAD;
      endcase
   end

   // Mode is latched from the first beat only; in_last is checked but never ends a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= LOAD;
         r_wrCnt    <= '0;
         r_rdCnt    <= '0;
         r_mode     <= 1'b0;
         r_frameErr <= 1'b0;
         for (int i = 0; i < LANES; i++) r_sum[i] <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_inFire) begin
            if (r_wrCnt == '0) r_mode <= mode;
            r_wrCnt <= w_inLastBeat ? '0 : r_wrCnt + CNT_W'(1);
            if (bus.in_last != w_inLastBeat) r_frameErr <= 1'b1;
            for (int i = 0; i < LANES; i++) r_sum[i] <= w_sumNext[i];
         end
         if (w_outFire) begin
            r_rdCnt <= w_outLastBeat ? '0 : r_rdCnt + CNT_W'(1);
            if (w_outLastBeat) for (int i = 0; i < LANES; i++) r_sum[i] <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_inFire) r_buf[r_wrCnt] <= bus.in_data;
   end

`ifdef BCAU_STATS_EN
   logic [LANES*PIX_W-1:0] r_statMean;
   logic                   r_statValid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_statMean  <= '0;
         r_statValid <= 1'b0;
      end else begin
         r_statValid <= w_divEnd;
         if (w_divEnd) for (int i = 0; i < LANES; i++) r_statMean[i*PIX_W +: PIX_W] <= w_mean[i];
      end
   end

   assign stat_mean  = r_statMean;
   assign stat_valid = r_statValid;
`endif
endmodule

// File: tb/tb_bcau_stream.sv
// Directed frame-level bench for bcau_stream: table of frames with hand-computed means and edge beats,
// plus hand-written sequences for reset abort, mode switching, backpressure and framing errors.
module tb_bcau_stream;
   localparam int LANES    = 5;
   localparam int DEPTH    = 80;
   localparam int PIX_W    = 8;
   localparam int TARGET   = 128;
   localparam int LAT_NORM = PIX_W + $clog2(DEPTH) + 1;

   typedef logic [0:LANES-1][8:0] lanes_t;
   typedef struct packed {
      logic [3:0] pat;
      logic       mode;
      lanes_t     mean;
      lanes_t     first;
      lanes_t     last;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic mode;
   logic frame_err;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[4];
   vec_t vecBypass;

   bcau_stream_if #(.LANES(LANES), .PIX_W(PIX_W)) bus ();

`ifdef BCAU_STATS_EN
   logic [LANES*PIX_W-1:0] statMean;
   logic                   statValid;
`endif

   bcau_stream #(.LANES(LANES), .DEPTH(DEPTH), .PIX_W(PIX_W), .TARGET(TARGET)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .bus       (bus),
      .frame_err (frame_err)
`ifdef BCAU_STATS_EN
      ,
      .stat_mean  (statMean),
      .stat_valid (statValid)
`endif
   );

   always #5 clk = ~clk;

   function automatic lanes_t mkLanes(input int a, input int b, input int c, input int d, input int e);
      return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e)};
   endfunction

   function automatic vec_t mkVec(input int pat, input bit m, input lanes_t mean, input lanes_t first, input lanes_t last);
      vec_t v;
      v.pat = 4'(pat);
      v.mode = m;
      v.mean = mean;
      v.first = first;
      v.last = last;
      return v;
   endfunction

   function automatic int genPix(input int pat, input int b, input int lane);
      case (pat)
         0: return 40;
         1: case (lane)
               0: return b * 3;
               1: return (b == 0) ? 255 : 0;
               2: return 255;
               3: return 0;
               default: return b;
            endcase
         2: case (lane)
               0: return (b == 0) ? 0 : 200;
               1: return (b == DEPTH - 1) ? 255 : 0;
               2: return 10;
               3: return (b % 2 == 1) ? 250 : 0;
               default: return 255 - b;
            endcase
         default: return (b * 37 + lane * 91 + 5) % 256;
      endcase
   endfunction

   // Edge beats come straight from the table; interior beats use the hand-computed lane mean.
   function automatic int expPix(input vec_t v, input int b, input int lane);
      int p;
      p = genPix(int'(v.pat), b, lane);
      if (b == 0) return int'(v.first[lane]);
      if (b == DEPTH - 1) return int'(v.last[lane]);
      if (!v.mode) return p;
      p = p - int'(v.mean[lane]) + TARGET;
      return (p < 0) ? 0 : (p > 255) ? 255 : p;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int pat, input bit modeFirst, input int switchBeat,
                                input bit modeLater, input int errBeat, input int nBeats);
      for (int b = 0; b < nBeats; b++) begin
         int waitCnt = 0;
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_last  = (b == DEPTH - 1) || (b == errBeat);
         mode         = (b >= switchBeat) ? modeLater : modeFirst;
         for (int l = 0; l < LANES; l++) bus.in_data[l*PIX_W +: PIX_W] = PIX_W'(genPix(pat, b, l));
         if (errBeat >= 0 && b == errBeat) checkOutput("frame_err_before", int'(frame_err), 0);
         if (errBeat >= 0 && b == errBeat + 1) checkOutput("frame_err_set", int'(frame_err), 1);
         while (!bus.in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
         end
         if (waitCnt != 0) checkOutput("in_ready_load", int'(bus.in_ready), 1);
      end
   endtask

   task automatic drainFrame(input vec_t v, input int readyPct, input int expLat);
      int lat = 1;
      int idx = 0;
      int guard = 0;
      bit rdy;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      while (!bus.out_valid && lat < 100) begin
         checkOutput("in_ready_div", int'(bus.in_ready), 0);
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", lat, expLat);
      while (idx < DEPTH && guard < 2000) begin
         if (bus.out_valid) begin
            for (int l = 0; l < LANES; l++)
               checkOutput($sformatf("beat%0d_lane%0d", idx, l), int'(bus.out_data[l*PIX_W +: PIX_W]), expPix(v, idx, l));
            checkOutput("out_last", int'(bus.out_last), int'(idx == DEPTH - 1));
            checkOutput("in_ready_drain", int'(bus.in_ready), 0);
         end
         rdy = (int'($urandom_range(99)) < readyPct);
         bus.out_ready = rdy;
         if (bus.out_valid && rdy) idx++;
         @(negedge clk);
         guard++;
      end
      bus.out_ready = 1'b0;
      checkOutput("beats_drained", idx, DEPTH);
      checkOutput("out_valid_after", int'(bus.out_valid), 0);
      checkOutput("in_ready_after", int'(bus.in_ready), 1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      mode          = 1'b0;
      rst           = 1'b1;

      vecs[0] = mkVec(0, 1'b1, mkLanes(40, 40, 40, 40, 40),
                      mkLanes(128, 128, 128, 128, 128), mkLanes(128, 128, 128, 128, 128));
      vecs[1] = mkVec(1, 1'b1, mkLanes(118, 3, 255, 0, 39),
                      mkLanes(10, 255, 128, 128, 89), mkLanes(247, 125, 128, 128, 168));
      vecs[2] = mkVec(2, 1'b1, mkLanes(197, 3, 10, 125, 215),
                      mkLanes(0, 125, 128, 3, 168), mkLanes(131, 255, 128, 253, 89));
      vecs[3] = mkVec(2, 1'b0, mkLanes(0, 0, 0, 0, 0),
                      mkLanes(0, 0, 10, 0, 255), mkLanes(200, 255, 10, 250, 176));
      vecBypass = mkVec(3, 1'b0, mkLanes(0, 0, 0, 0, 0),
                        mkLanes(5, 96, 187, 22, 113), mkLanes(112, 203, 38, 129, 220));

      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", int'(bus.in_ready), 1);
      checkOutput("rst_out_valid", int'(bus.out_valid), 0);
      checkOutput("rst_out_last", int'(bus.out_last), 0);
      checkOutput("rst_frame_err", int'(frame_err), 0);
      checkOutput("rst_out_data_zero", int'(bus.out_data == '0), 1);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         applyStimulus(int'(vecs[i].pat), vecs[i].mode, DEPTH, vecs[i].mode, -1, DEPTH);
         drainFrame(vecs[i], 100, vecs[i].mode ? LAT_NORM : 1);
         checkOutput($sformatf("frame_err_clean_%0d", i), int'(frame_err), 0);
      end

      $display("[TB] mode switched to bypass mid-frame, then a bypass frame");
      applyStimulus(1, 1'b1, 10, 1'b0, -1, DEPTH);
      drainFrame(vecs[1], 100, LAT_NORM);
      applyStimulus(3, 1'b0, DEPTH, 1'b0, -1, DEPTH);
      drainFrame(vecBypass, 100, 1);

      $display("[TB] backpressure on the output");
      applyStimulus(1, 1'b1, DEPTH, 1'b1, -1, DEPTH);
      drainFrame(vecs[1], 30, LAT_NORM);

      $display("[TB] early in_last on beat 50");
      applyStimulus(1, 1'b1, DEPTH, 1'b1, 50, DEPTH);
      drainFrame(vecs[1], 100, LAT_NORM);
      checkOutput("frame_err_sticky", int'(frame_err), 1);

      $display("[TB] reset in the middle of LOAD");
      applyStimulus(2, 1'b1, DEPTH, 1'b1, -1, 30);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("abort_in_ready", int'(bus.in_ready), 1);
      checkOutput("abort_out_valid", int'(bus.out_valid), 0);
      checkOutput("abort_frame_err", int'(frame_err), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_out_valid_post", int'(bus.out_valid), 0);
      applyStimulus(0, 1'b1, DEPTH, 1'b1, -1, DEPTH);
      drainFrame(vecs[0], 100, LAT_NORM);
      checkOutput("abort_frame_err_final", int'(frame_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
